// File: rtl/bru_notif_arbiter_pkg.sv
// Arbiter-local types and width helpers shared by the arbiter, its FIFOs
// and the bus interface.
package bru_notif_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Index width for n items; a single item still gets one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold a count from 0 to depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/core_types_pkg.sv
// Core-wide shared types. The branch notification record is produced by
// bru_pipeline and consumed by the ROB through the notification arbiter.
package core_types_pkg;

    localparam int LOG_ROB_ENTRIES     = 6;
    localparam int BTB_PRED_INFO_WIDTH = 8;

    typedef struct packed {
        logic [LOG_ROB_ENTRIES-1:0]     ROB_index;
        logic                           is_mispredict;
        logic                           is_taken;
        logic                           use_upct;
        logic [BTB_PRED_INFO_WIDTH-1:0] updated_pred_info;
        logic                           pred_lru;
        logic [31:0]                    start_PC;
        logic [31:0]                    target_PC;
    } bru_notif_t;

endpackage

// File: rtl/bru_notif_arbiter_if.sv
// Bus between the BRU pipelines / ROB side (master) and the notification
// arbiter (slave).
interface bru_notif_arbiter_if #(
    parameter int NUM_CHANNELS = 2,
    parameter int FIFO_DEPTH   = 2
);
    import core_types_pkg::*;
    import bru_notif_arbiter_pkg::*;

    localparam int CH_W  = idx_width(NUM_CHANNELS);
    localparam int OCC_W = cnt_width(FIFO_DEPTH);

    logic       [NUM_CHANNELS-1:0]            in_valid;
    bru_notif_t [NUM_CHANNELS-1:0]            in_notif;
    logic       [NUM_CHANNELS-1:0]            in_ready;
    logic                                     out_valid;
    bru_notif_t                               out_notif;
    logic       [CH_W-1:0]                    out_channel;
    logic                                     out_ready;
    logic                                     flush_valid;
    logic       [NUM_CHANNELS-1:0][OCC_W-1:0] occupancy;

    modport master (
        output in_valid, in_notif, out_ready, flush_valid,
        input  in_ready, out_valid, out_notif, out_channel, occupancy
    );

    modport slave (
        input  in_valid, in_notif, out_ready, flush_valid,
        output in_ready, out_valid, out_notif, out_channel, occupancy
    );

endinterface

// File: rtl/bru_notif_fifo.sv
// Per-channel notification FIFO of any depth 1..8. The pointers wrap
// explicitly at FIFO_DEPTH-1; payload storage is deliberately not reset.
module bru_notif_fifo
    import core_types_pkg::*;
    import bru_notif_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                             CLK,
    input  logic                             nRST,
    input  logic                             flush,
    input  logic                             push,
    input  logic                             pop,
    input  bru_notif_t                       wdata,
    output bru_notif_t                       head,
    output logic [cnt_width(FIFO_DEPTH)-1:0] count
);

    localparam int PTR_W = idx_width(FIFO_DEPTH);
    localparam int CNT_W = cnt_width(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] ZERO_PTR = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] ONE_PTR  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};

    bru_notif_t       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;

    // Next pointer and count values; flush wins over any push or pop.
    always_comb begin
        rd_ptr_nxt_s = rd_ptr_r;
        wr_ptr_nxt_s = wr_ptr_r;
        count_nxt_s  = count_r;
        if (flush) begin
            rd_ptr_nxt_s = ZERO_PTR;
            wr_ptr_nxt_s = ZERO_PTR;
            count_nxt_s  = ZERO_CNT;
        end else begin
            if (push) begin
                wr_ptr_nxt_s = (wr_ptr_r == LAST_PTR) ? ZERO_PTR : wr_ptr_r + ONE_PTR;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_nxt_s = (rd_ptr_r == LAST_PTR) ? ZERO_PTR : rd_ptr_r + ONE_PTR;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({push, pop})
                2'b10:   count_nxt_s = count_r + ONE_CNT;
                2'b01:   count_nxt_s = count_r - ONE_CNT;
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_ptr_r <= ZERO_PTR;
            wr_ptr_r <= ZERO_PTR;
            count_r  <= ZERO_CNT;
        end else begin
            rd_ptr_r <= rd_ptr_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            count_r  <= count_nxt_s;
        end
    end

    // Payload storage write.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/bru_notif_arbiter.sv
// Merges branch notifications from several BRU pipelines into the single ROB
// notification port: per-channel FIFOs, round-robin with optional mispredict
// priority, and a lock that holds the offered notification until accepted.
module bru_notif_arbiter
    import core_types_pkg::*;
    import bru_notif_arbiter_pkg::*;
#(
    parameter int NUM_CHANNELS  = 2,
    parameter int FIFO_DEPTH    = 2,
    parameter int MISPRED_FIRST = 1
) (
    input logic                CLK,
    input logic                nRST,
    bru_notif_arbiter_if.slave bus
);

    localparam int CH_W  = idx_width(NUM_CHANNELS);
    localparam int CNT_W = cnt_width(FIFO_DEPTH);
    localparam logic [CH_W-1:0]  ZERO_CH  = {CH_W{1'b0}};
    localparam logic [CH_W-1:0]  ONE_CH   = {{(CH_W-1){1'b0}}, 1'b1};
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CHANNELS - 1);
    localparam logic [CH_W:0]    NUM_EXT  = (CH_W+1)'(NUM_CHANNELS);
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    bru_notif_t [NUM_CHANNELS-1:0]            head_s;
    logic       [NUM_CHANNELS-1:0][CNT_W-1:0] count_s;
    logic       [NUM_CHANNELS-1:0]            nonempty_s;
    logic       [NUM_CHANNELS-1:0]            mispred_s;
    logic       [NUM_CHANNELS-1:0]            cand_s;
    logic       [NUM_CHANNELS-1:0]            in_ready_s;
    logic       [NUM_CHANNELS-1:0]            push_s;
    logic       [NUM_CHANNELS-1:0]            pop_s;
    logic                                     any_nonempty_s;
    logic                                     out_valid_s;
    logic                                     deq_s;
    logic                                     found_s;
    logic       [CH_W:0]                      idx_s;
    logic       [CH_W-1:0]                    scan_ch_s;
    logic       [CH_W-1:0]                    sel_ch_s;
    logic       [CH_W-1:0]                    rr_ptr_r;
    logic       [CH_W-1:0]                    rr_ptr_nxt_s;
    logic       [CH_W-1:0]                    lock_ch_r;
    logic       [CH_W-1:0]                    lock_ch_nxt_s;
    arb_state_t                               state_r;
    arb_state_t                               state_nxt_s;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        assign nonempty_s[i] = (count_s[i] != ZERO_CNT);
        assign in_ready_s[i] = (count_s[i] != FULL_CNT) && !bus.flush_valid;
        assign push_s[i]     = bus.in_valid[i] && in_ready_s[i];
        assign pop_s[i]      = deq_s && (sel_ch_s == CH_W'(i));
        assign mispred_s[i]  = nonempty_s[i] && head_s[i].is_mispredict;

        bru_notif_fifo #(
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .CLK   (CLK),
            .nRST  (nRST),
            .flush (bus.flush_valid),
            .push  (push_s[i]),
            .pop   (pop_s[i]),
            .wdata (bus.in_notif[i]),
            .head  (head_s[i]),
            .count (count_s[i])
        );
    end

    assign any_nonempty_s = |nonempty_s;
    assign out_valid_s    = any_nonempty_s && !bus.flush_valid;
    assign deq_s          = out_valid_s && bus.out_ready;

    // Rotating scan from rr_ptr over the candidate heads (mispredicts only, if any and enabled).
    always_comb begin
        cand_s    = ((MISPRED_FIRST != 0) && (|mispred_s)) ? mispred_s : nonempty_s;
        found_s   = 1'b0;
        scan_ch_s = ZERO_CH;
        idx_s     = {(CH_W+1){1'b0}};
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            idx_s     = {1'b0, rr_ptr_r} + (CH_W+1)'(k);
            idx_s     = (idx_s >= NUM_EXT) ? idx_s - NUM_EXT : idx_s;
            scan_ch_s = (!found_s && cand_s[idx_s[CH_W-1:0]]) ? idx_s[CH_W-1:0] : scan_ch_s;
            found_s   = found_s || cand_s[idx_s[CH_W-1:0]];
        end
    end

    // A locked offer keeps its channel even if a better head shows up elsewhere.
    assign sel_ch_s = (state_r == ARB_LOCKED) ? lock_ch_r : scan_ch_s;

    // Lock FSM and round-robin pointer next state.
    always_comb begin
        state_nxt_s   = state_r;
        lock_ch_nxt_s = lock_ch_r;
        rr_ptr_nxt_s  = rr_ptr_r;
        if (bus.flush_valid) begin
            state_nxt_s   = ARB_OPEN;
            lock_ch_nxt_s = ZERO_CH;
            rr_ptr_nxt_s  = ZERO_CH;
        end else begin
            case (state_r)
                ARB_OPEN: begin
                    if (out_valid_s && !bus.out_ready) begin
                        state_nxt_s   = ARB_LOCKED;
                        lock_ch_nxt_s = scan_ch_s;
                    end else begin
                        state_nxt_s = ARB_OPEN;
                    end
                end
                ARB_LOCKED: begin
                    if (deq_s) begin
                        state_nxt_s = ARB_OPEN;
                    end else begin
                        state_nxt_s = ARB_LOCKED;
                    end
                end
                default: state_nxt_s = ARB_OPEN;
            endcase
            if (deq_s) begin
                rr_ptr_nxt_s = (sel_ch_s == LAST_CH) ? ZERO_CH : sel_ch_s + ONE_CH;
            end else begin
                rr_ptr_nxt_s = rr_ptr_r;
            end
        end
    end

    // Lock FSM and round-robin pointer registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r   <= ARB_OPEN;
            lock_ch_r <= ZERO_CH;
            rr_ptr_r  <= ZERO_CH;
        end else begin
            state_r   <= state_nxt_s;
            lock_ch_r <= lock_ch_nxt_s;
            rr_ptr_r  <= rr_ptr_nxt_s;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_s;
    assign bus.out_notif   = head_s[sel_ch_s];
    assign bus.out_channel = any_nonempty_s ? sel_ch_s : ZERO_CH;
    assign bus.occupancy   = count_s;

endmodule

// File: tb/tb_bru_notif_arbiter.sv
// Bench for bru_notif_arbiter: per-channel scoreboard of enqueued payloads,
// directed arbitration/lock/flush/reset scenarios and a random soak.
module tb_bru_notif_arbiter;
    import core_types_pkg::*;

    localparam int NCH   = 2;
    localparam int DEPTH = 3;

    logic       CLK = 1'b0;
    logic       nRST;
    int         checks = 0;
    int         errors = 0;
    int         seq [NCH];
    logic       mp_mode;
    bru_notif_t sb_q [NCH][$];
    bru_notif_t exp_v;
    bru_notif_t exp0;

    always #5 CLK = ~CLK;

    bru_notif_arbiter_if #(.NUM_CHANNELS(NCH), .FIFO_DEPTH(DEPTH)) bus_a ();
    bru_notif_arbiter_if #(.NUM_CHANNELS(NCH), .FIFO_DEPTH(DEPTH)) bus_b ();

    assign bus_b.in_valid    = bus_a.in_valid;
    assign bus_b.in_notif    = bus_a.in_notif;
    assign bus_b.out_ready   = bus_a.out_ready;
    assign bus_b.flush_valid = bus_a.flush_valid;

    bru_notif_arbiter #(.NUM_CHANNELS(NCH), .FIFO_DEPTH(DEPTH), .MISPRED_FIRST(1)) dut_a (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus_a)
    );

    bru_notif_arbiter #(.NUM_CHANNELS(NCH), .FIFO_DEPTH(DEPTH), .MISPRED_FIRST(0)) dut_b (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus_b)
    );

    function automatic bru_notif_t make_notif(input int ch, input int s, input logic mp);
        bru_notif_t n;
        n.ROB_index         = LOG_ROB_ENTRIES'(s);
        n.is_mispredict     = mp;
        n.is_taken          = s[0];
        n.use_upct          = s[1];
        n.updated_pred_info = BTB_PRED_INFO_WIDTH'(s * 3);
        n.pred_lru          = ch[0];
        n.start_PC          = 32'(ch * 32'h1000_0000 + s * 4);
        n.target_PC         = 32'(s * 17 + ch);
        return n;
    endfunction

    // One clock: sample handshakes at negedge into the scoreboard, return at posedge+1.
    task automatic tick();
        logic [NCH-1:0] pushed;
        pushed = '0;
        @(negedge CLK);
        if (nRST) begin
            for (int c = 0; c < NCH; c++) begin
                if (bus_a.in_valid[c] && bus_a.in_ready[c]) begin
                    sb_q[c].push_back(bus_a.in_notif[c]);
                    pushed[c] = 1'b1;
                end
            end
            if (bus_a.out_valid && bus_a.out_ready) begin
                checks++;
                if (sb_q[bus_a.out_channel].size() == 0) begin
                    errors++;
                    $display("FAIL sb_pop ch=%0d got dequeue of %h required no dequeue (queue empty)",
                             bus_a.out_channel, bus_a.out_notif);
                end else begin
                    exp_v = sb_q[bus_a.out_channel].pop_front();
                    if (bus_a.out_notif !== exp_v) begin
                        errors++;
                        $display("FAIL sb_payload ch=%0d got %h required %h",
                                 bus_a.out_channel, bus_a.out_notif, exp_v);
                    end
                end
            end
            if (bus_a.flush_valid) begin
                for (int c = 0; c < NCH; c++) sb_q[c].delete();
            end
        end
        @(posedge CLK);
        #1;
        for (int c = 0; c < NCH; c++) begin
            if (pushed[c]) begin
                seq[c]++;
                bus_a.in_notif[c] = make_notif(c, seq[c], mp_mode && ($urandom_range(0, 2) == 0));
            end
        end
    endtask

    task automatic drain();
        bus_a.in_valid  = '0;
        bus_a.out_ready = 1'b1;
        for (int n = 0; n < 40 && bus_a.out_valid; n++) tick();
    endtask

    task automatic do_flush();
        bus_a.flush_valid = 1'b1;
        tick();
        bus_a.flush_valid = 1'b0;
    endtask

    task automatic test_reset();
        nRST              = 1'b0;
        mp_mode           = 1'b0;
        bus_a.in_valid    = '0;
        bus_a.out_ready   = 1'b0;
        bus_a.flush_valid = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            seq[c] = 0;
            bus_a.in_notif[c] = make_notif(c, 0, 1'b0);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", bus_a.out_valid); end
        checks++;
        if (bus_a.out_channel !== 1'b0) begin errors++; $display("FAIL reset_out_channel got %0d required 0", bus_a.out_channel); end
        checks++;
        if (bus_a.occupancy !== 4'h0) begin errors++; $display("FAIL reset_occupancy got %h required 0", bus_a.occupancy); end
        nRST = 1'b1;
        tick();
        checks++;
        if (bus_a.in_ready !== 2'b11) begin errors++; $display("FAIL reset_in_ready got %b required 11", bus_a.in_ready); end
    endtask

    task automatic test_fairness();
        bus_a.in_valid  = 2'b11;
        bus_a.out_ready = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (bus_a.out_valid !== 1'b1 || bus_a.out_channel !== 1'(k % 2)) begin
                errors++;
                $display("FAIL fairness_step%0d got valid=%b ch=%0d required valid=1 ch=%0d",
                         k, bus_a.out_valid, bus_a.out_channel, k % 2);
            end
            tick();
        end
        drain();
        checks++;
        if (bus_a.out_valid !== 1'b0 || sb_q[0].size() != 0 || sb_q[1].size() != 0) begin
            errors++;
            $display("FAIL fairness_drain got valid=%b sb=%0d/%0d required valid=0 sb=0/0",
                     bus_a.out_valid, sb_q[0].size(), sb_q[1].size());
        end
    endtask

    task automatic test_mispredict();
        do_flush();
        bus_a.in_notif[0] = make_notif(0, 50, 1'b0);
        bus_a.in_notif[1] = make_notif(1, 60, 1'b1);
        bus_a.in_valid    = 2'b11;
        bus_a.out_ready   = 1'b0;
        tick();
        bus_a.in_valid = 2'b00;
        #1;
        checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_channel !== 1'b1) begin
            errors++; $display("FAIL mp_first_sel got valid=%b ch=%0d required valid=1 ch=1", bus_a.out_valid, bus_a.out_channel);
        end
        checks++;
        if (bus_b.out_valid !== 1'b1 || bus_b.out_channel !== 1'b0) begin
            errors++; $display("FAIL mp_rr_sel got valid=%b ch=%0d required valid=1 ch=0", bus_b.out_valid, bus_b.out_channel);
        end
        bus_a.out_ready = 1'b1;
        tick();
        checks++;
        if (bus_a.out_channel !== 1'b0) begin errors++; $display("FAIL mp_first_next got ch=%0d required 0", bus_a.out_channel); end
        checks++;
        if (bus_b.out_channel !== 1'b1) begin errors++; $display("FAIL mp_rr_next got ch=%0d required 1", bus_b.out_channel); end
        tick();
        checks++;
        if (bus_a.out_valid !== 1'b0 || bus_a.out_channel !== 1'b0 || bus_b.out_valid !== 1'b0 || bus_b.out_channel !== 1'b0) begin
            errors++;
            $display("FAIL mp_empty got a=%b/%0d b=%b/%0d required 0/0 0/0",
                     bus_a.out_valid, bus_a.out_channel, bus_b.out_valid, bus_b.out_channel);
        end
    endtask

    task automatic test_lock();
        do_flush();
        exp0 = make_notif(0, 200, 1'b0);
        bus_a.in_notif[0] = exp0;
        bus_a.in_valid    = 2'b01;
        bus_a.out_ready   = 1'b0;
        tick();
        bus_a.in_notif[1] = make_notif(1, 201, 1'b1);
        bus_a.in_valid    = 2'b10;
        #1;
        checks++;
        if (bus_a.out_channel !== 1'b0 || bus_a.out_notif !== exp0) begin
            errors++; $display("FAIL lock_initial got ch=%0d notif=%h required ch=0 notif=%h", bus_a.out_channel, bus_a.out_notif, exp0);
        end
        tick();
        bus_a.in_valid = 2'b00;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus_a.out_channel !== 1'b0 || bus_a.out_notif !== exp0) begin
                errors++;
                $display("FAIL lock_hold%0d got ch=%0d notif=%h required ch=0 notif=%h",
                         k, bus_a.out_channel, bus_a.out_notif, exp0);
            end
            tick();
        end
        bus_a.out_ready = 1'b1;
        #1;
        checks++;
        if (bus_a.out_channel !== 1'b0) begin errors++; $display("FAIL lock_release got ch=%0d required 0", bus_a.out_channel); end
        tick();
        checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_channel !== 1'b1) begin
            errors++; $display("FAIL lock_next got valid=%b ch=%0d required valid=1 ch=1", bus_a.out_valid, bus_a.out_channel);
        end
        tick();
        checks++;
        if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL lock_empty got valid=%b required 0", bus_a.out_valid); end
    endtask

    task automatic test_full_wrap();
        do_flush();
        bus_a.in_valid  = 2'b01;
        bus_a.out_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (bus_a.in_ready[0] !== 1'b0 || bus_a.occupancy[0] !== 2'd3) begin
            errors++; $display("FAIL full_state got in_ready0=%b occ0=%0d required 0 3", bus_a.in_ready[0], bus_a.occupancy[0]);
        end
        tick();
        checks++;
        if (bus_a.occupancy[0] !== 2'd3) begin errors++; $display("FAIL full_no_overrun got occ0=%0d required 3", bus_a.occupancy[0]); end
        bus_a.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (bus_a.occupancy[0] !== 2'(sb_q[0].size())) begin
                errors++; $display("FAIL wrap_occ%0d got %0d required %0d", k, bus_a.occupancy[0], sb_q[0].size());
            end
        end
        drain();
        checks++;
        if (bus_a.out_valid !== 1'b0 || sb_q[0].size() != 0 || bus_a.occupancy !== 4'h0) begin
            errors++;
            $display("FAIL wrap_drain got valid=%b sb=%0d occ=%h required valid=0 sb=0 occ=0",
                     bus_a.out_valid, sb_q[0].size(), bus_a.occupancy);
        end
    endtask

    task automatic test_flush();
        do_flush();
        bus_a.in_valid  = 2'b01;
        bus_a.out_ready = 1'b0;
        repeat (2) tick();
        bus_a.flush_valid = 1'b1;
        #1;
        checks++;
        if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 2'b00) begin
            errors++; $display("FAIL flush_same_cycle got valid=%b in_ready=%b required 0 00", bus_a.out_valid, bus_a.in_ready);
        end
        tick();
        bus_a.flush_valid = 1'b0;
        bus_a.in_valid    = 2'b00;
        #1;
        checks++;
        if (bus_a.occupancy !== 4'h0 || bus_a.out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_next got occ=%h valid=%b required 0 0", bus_a.occupancy, bus_a.out_valid);
        end
        tick();
        checks++;
        if (bus_a.occupancy !== 4'h0) begin errors++; $display("FAIL flush_no_enq got occ=%h required 0", bus_a.occupancy); end
    endtask

    task automatic test_reset_mid();
        bus_a.in_valid  = 2'b11;
        bus_a.out_ready = 1'b0;
        repeat (2) tick();
        bus_a.in_valid = 2'b00;
        checks++;
        if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre got valid=%b required 1", bus_a.out_valid); end
        nRST = 1'b0;
        #1;
        checks++;
        if (bus_a.out_valid !== 1'b0 || bus_a.out_channel !== 1'b0 || bus_a.occupancy !== 4'h0) begin
            errors++;
            $display("FAIL rstmid_async got valid=%b ch=%0d occ=%h required 0 0 0",
                     bus_a.out_valid, bus_a.out_channel, bus_a.occupancy);
        end
        for (int c = 0; c < NCH; c++) sb_q[c].delete();
        tick();
        nRST            = 1'b1;
        bus_a.out_ready = 1'b1;
        tick();
        checks++;
        if (bus_a.in_ready !== 2'b11 || bus_a.occupancy !== 4'h0) begin
            errors++; $display("FAIL rstmid_release got in_ready=%b occ=%h required 11 0", bus_a.in_ready, bus_a.occupancy);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_deq%0d got valid=%b required 0", k, bus_a.out_valid); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        do_flush();
        mp_mode = 1'b1;
        for (int n = 0; n < 200; n++) begin
            bus_a.in_valid  = 2'($urandom_range(0, 3));
            bus_a.out_ready = ($urandom_range(0, 9) < 7);
            tick();
            for (int c = 0; c < NCH; c++) begin
                checks++;
                if (bus_a.occupancy[c] !== 2'(sb_q[c].size())) begin
                    errors++; $display("FAIL rand_occ n=%0d ch=%0d got %0d required %0d", n, c, bus_a.occupancy[c], sb_q[c].size());
                end
                checks++;
                if (bus_a.in_ready[c] !== (sb_q[c].size() != DEPTH)) begin
                    errors++; $display("FAIL rand_in_ready n=%0d ch=%0d got %b required %b",
                                       n, c, bus_a.in_ready[c], sb_q[c].size() != DEPTH);
                end
            end
        end
        mp_mode = 1'b0;
        drain();
        checks++;
        if (bus_a.out_valid !== 1'b0 || sb_q[0].size() != 0 || sb_q[1].size() != 0) begin
            errors++;
            $display("FAIL rand_drain got valid=%b sb=%0d/%0d required valid=0 sb=0/0",
                     bus_a.out_valid, sb_q[0].size(), sb_q[1].size());
        end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_mispredict();
        test_lock();
        test_full_wrap();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
